// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
// Owns HI/LO, runs mult/multu/div/divu over a fixed number of cycles, executes
// mthi/mtlo in one cycle, and raises the stall request for the hazard logic.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_instr_D,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        start,
  output logic        stall_md
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;   // 0 when the result must be dropped (divide by zero)

  // Datapath signals computed from the E-stage operands.
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [63:0] result;
  logic        result_wr;
  logic        is_mul, is_multi;

  // Arithmetic: both products and a sign-magnitude divide, selected by md_op.
  always_comb begin
    prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    // Dividing magnitudes makes truncation toward zero explicit, and
    // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
    div_signed = (md_op == OP_DIV);
    a_mag  = (div_signed && rs_val[31]) ? -rs_val : rs_val;
    b_mag  = (div_signed && rt_val[31]) ? -rt_val : rt_val;
    b_safe = (rt_val == 32'd0) ? 32'd1 : b_mag;   // keeps the divider defined on /0
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (div_signed && (rs_val[31] ^ rt_val[31])) ? -q_mag : q_mag;
    rem    = (div_signed && rs_val[31]) ? -r_mag : r_mag;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    result    = 64'd0;
    result_wr = 1'b0;
    case (md_op)
      OP_MULT:          begin result = prod_s;      result_wr = 1'b1; end
      OP_MULTU:         begin result = prod_u;      result_wr = 1'b1; end
      OP_DIV, OP_DIVU:  begin result = {rem, quot}; result_wr = (rt_val != 32'd0); end
      default:          ;
    endcase
  end

  assign is_mul   = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_multi = is_mul || (md_op == OP_DIV) || (md_op == OP_DIVU);

  assign start    = op_valid && is_multi && (state_q == S_IDLE);
  assign busy     = (state_q == S_BUSY);
  assign stall_md = md_instr_D && (start || busy);
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

  // Next-state: launch multi-cycle ops, count them down, commit on the last edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pend_hi_d = result[63:32];
          pend_lo_d = result[31:0];
          pend_wr_d = result_wr;
          cnt_d     = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_d   = S_BUSY;
        end else if (op_valid && md_op == OP_MTHI) begin
          hi_d = rs_val;
        end else if (op_valid && md_op == OP_MTLO) begin
          lo_d = rs_val;
        end
      end
      S_BUSY: begin
        // New ops arriving here are ignored: nothing above reads op_valid in BUSY.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight result.
  // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      // NOTE: the pending result is reset too, so nothing from an aborted operation can leak into a later commit.
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult/multu/div/divu over multiple cycles.
- Executes mthi/mtlo in a single cycle.
- Produces the busy/stall request that the hazard logic consumes. It is the other end of the stall interface: it generates the condition, and hazard logic freezes the F/D stages on it.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (must be >=1).
- DIV_CYCLES, 10, cycles busy is held for div/divu (must be >=1).
- CNT_W, 4, width of the cycle counter (must hold max(MULT_CYCLES, DIV_CYCLES)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  E-stage instruction is a valid MD op this cycle (already gated by flush/bubble).
- md_op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- rs_val  in  32  forwarded rs operand from E stage.
- rt_val  in  32  forwarded rt operand from E stage.
- md_instr_D  in  1  D-stage instruction is any MD-class op (mult/multu/div/divu/mthi/mtlo/mfhi/mflo).
- hi_out  out  32  architectural HI.
- lo_out  out  32  architectural LO.
- busy  out  1  multi-cycle operation in progress.
- start  out  1  combinational: op_valid & md_op in {001..100} & state==IDLE.
- stall_md  out  1  combinational: md_instr_D & (start | busy).

Behaviour:
- Reset (reset==0, async): state=IDLE, busy=0, hi_out=0, lo_out=0, counter=0, pending HI/LO=0. Takes effect immediately, including mid-operation. The in-flight result is discarded.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1.
- IDLE, start=1 at edge T0:
  - Latch op type and compute the pending result from rs_val/rt_val.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter reaches 0: commit pending HI/LO to hi_out/lo_out, go to IDLE.
  - busy is high for exactly N cycles (T0+1 .. T0+N). New HI/LO are visible from T0+N.
- mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
- multu: unsigned 32x32 -> 64; HI=[63:32], LO=[31:0].
- div:
  - Signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned; LO=quotient, HI=remainder.
- Divide by zero (rt_val==0 on div/divu): busy is still held DIV_CYCLES; at commit, hi_out/lo_out keep their prior values.
- mthi/mtlo in IDLE with op_valid: hi_out (or lo_out) <= rs_val at that edge. No busy; state stays IDLE.
- Any op_valid MD op while BUSY: ignored. Operands are not latched, HI/LO are unchanged, the counter is undisturbed. Correct hazard logic never issues this; the bench checks that it is ignored.
- md_op none/reserved, or op_valid=0: no effect.
- stall_md covers the start cycle itself (busy is still 0 then) so that a following mfhi/mflo/MD op in D is held.
- hi_out/lo_out are registered; reads (mfhi/mflo) sample them directly.

Test Plan:
- Signed mult: mult rs=0xFFFFFFFD (-3), rt=5 -> busy=1 for 5 cycles; then hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1, busy=0.
- Unsigned divide: divu 100,7 -> busy for 10 cycles; then lo_out=14 (0xE), hi_out=2. Repeat div -7,2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- Overflow divide: div 0x80000000,0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- Divide by zero: first mthi 0x1234 and mtlo 0x5678 (each takes effect next edge, busy stays 0); then divu 9,0 -> busy 10 cycles, hi_out=0x1234, lo_out=0x5678 unchanged.
- Stall interface and issue while busy: with md_instr_D=1, stall_md=1 in the start cycle and all 5 busy cycles of a mult, and 0 on the following cycle. A second mult issued during BUSY is ignored, and the result equals the first mult only.
- Reset mid-operation: assert reset low at cycle 4 of a div -> busy=0, hi_out=lo_out=0 immediately. After release, a new multu 0xFFFFFFFF,2 gives hi_out=1, lo_out=0xFFFFFFFE.
